// File: rtl/mmio_port.sv
// mmio_port: memory-mapped output port with a small word FIFO.
// CPU writes to DATA push words into the FIFO; a stream consumer drains it
// through out_valid/out_ready. Registers: 0 DATA, 1 STATUS, 2 COUNT, 3 CYCLES.
// Optional feature macro: MMIO_PORT_CYCLES_EN (free-running 16-bit CYCLES
// counter); when undefined, CYCLES reads 0 and ignores writes.
module mmio_port #(
    parameter int         DEPTH = 4,
    parameter logic [7:0] BASE  = 8'hF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        sel,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready
);

    localparam int DATA_W = 16;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              ovf;

    logic              hit;
    logic [2:0]        off;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              accept;
    logic              ovf_set;
    logic              ovf_clr;
    logic [DATA_W-1:0] cycles_val;
    logic [DATA_W-1:0] rd_word;

    // addr[0] selects a byte within a word and has no meaning here
    logic unused_addr_lsb;
    assign unused_addr_lsb = addr[0];

    assign hit       = (addr[7:4] == BASE[7:4]);
    assign off       = addr[3:1];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted; only a push into a full FIFO without a pop overflows.
    assign pop     = out_valid && out_ready;
    assign push    = we && hit && (off == 3'd0);
    assign accept  = push && (!full || pop);
    assign ovf_set = push && full && !pop;
    assign ovf_clr = we && hit && (off == 3'd1) && wdata[2];

`ifdef MMIO_PORT_CYCLES_EN
    logic [DATA_W-1:0] cycles;
    logic              cyc_wr;

    assign cyc_wr     = we && hit && (off == 3'd3);
    assign cycles_val = cycles;

    // Free-running cycle counter; a CPU write loads it, then counting resumes
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles <= '0;
        end else if (cyc_wr) begin
            cycles <= wdata;
        end else begin
            cycles <= cycles + DATA_W'(1);
        end
    end
`else
    assign cycles_val = '0;
`endif

    // FIFO control: pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Overflow in the same cycle as a clear must leave the flag set
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care after reset so no reset here
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Register read mux over the state as it stands before this edge
    always_comb begin
        rd_word = '0;
        if (hit) begin
            case (off)
                3'd1:    rd_word = {13'b0, ovf, full, empty};
                3'd2:    rd_word = DATA_W'(count);
                3'd3:    rd_word = cycles_val;
                default: rd_word = '0;
            endcase
        end
    end

    // One-cycle registered read response and block-select flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            sel   <= 1'b0;
        end else begin
            rdata <= rd_word;
            sel   <= hit;
        end
    end

endmodule

// File: tb/tb_mmio_port.sv
// tb_mmio_port: scoreboard bench for mmio_port. A driver issues directed and
// random CPU/stream traffic and pushes expected read responses and expected
// popped words into queues from a queue-based model; monitors compare.
// Honours MMIO_PORT_CYCLES_EN the same way as the design.
module tb_mmio_port;

    localparam int         DEPTH = 4;
    localparam logic [7:0] BASE  = 8'hF0;

    logic        clk;
    logic        rst;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        sel;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    mmio_port #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mq[$];
    logic        m_ovf = 1'b0;
    logic [15:0] m_cyc = 16'h0;

    // Scoreboards: {sel, rdata} expected after each edge; popped words
    logic [16:0] rd_q[$];
    logic [15:0] pop_q[$];
    logic        exp_valid = 1'b0;
    logic        started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and advance the model across the coming edge
    task automatic step(input logic r, input logic w, input logic [7:0] a,
                        input logic [15:0] d, input logic rdy);
        logic        h;
        logic [2:0]  o;
        logic [15:0] rv;
        logic        f;
        logic        p;
        logic        oset;
        @(negedge clk);
        rst = r; we = w; addr = a; wdata = d; out_ready = rdy;
        h = (a[7:4] == BASE[7:4]);
        o = a[3:1];
        exp_valid = (mq.size() != 0);
        started = 1'b1;
        if (r) begin
            rd_q.push_back(17'h0);
            mq.delete();
            m_ovf = 1'b0;
            m_cyc = 16'h0;
        end else begin
            f = (mq.size() == DEPTH);
            rv = 16'h0;
            if (h) begin
                if (o == 3'd1) rv = {13'b0, m_ovf, f, mq.size() == 0};
                else if (o == 3'd2) rv = 16'(mq.size());
`ifdef MMIO_PORT_CYCLES_EN
                else if (o == 3'd3) rv = m_cyc;
`endif
            end
            rd_q.push_back({h, rv});
            p = (mq.size() != 0) && rdy;
            oset = 1'b0;
            if (p) pop_q.push_back(mq.pop_front());
            if (w && h && o == 3'd0) begin
                if (!f || p) mq.push_back(d);
                else oset = 1'b1;
            end
            if (oset) m_ovf = 1'b1;
            else if (w && h && o == 3'd1 && d[2]) m_ovf = 1'b0;
`ifdef MMIO_PORT_CYCLES_EN
            if (w && h && o == 3'd3) m_cyc = d;
            else m_cyc = m_cyc + 16'h1;
`endif
        end
    endtask

    // Read-response monitor: one expectation per driven cycle
    initial begin
        logic [16:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rd_q.size() != 0) begin
                e = rd_q.pop_front();
                chk("sel", {31'b0, sel}, {31'b0, e[16]});
                if (e[16]) chk("rdata", {16'b0, rdata}, {16'b0, e[15:0]});
            end
        end
    end

    // Stream monitor: checks out_valid and every word the consumer accepts
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (started && !rst) begin
                chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
                if (out_valid && out_ready) begin
                    if (pop_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop actual=%h expected=none at %0t", out_data, $time);
                    end else begin
                        chk("out_data", {16'b0, out_data}, {16'b0, pop_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; we = 1'b0; addr = 8'h00; wdata = 16'h0; out_ready = 1'b0;

        // Basic push/pop and COUNT
        step(1, 0, 8'h00, 16'h0, 0);
        step(1, 0, 8'h00, 16'h0, 0);
        step(0, 0, 8'hF4, 16'h0, 0);
        step(0, 0, 8'hF2, 16'h0, 0);
        step(0, 1, 8'hF0, 16'h1234, 0);
        step(0, 1, 8'hF0, 16'h5678, 0);
        step(0, 0, 8'hF4, 16'h0, 0);
        step(0, 0, 8'hF4, 16'h0, 1);
        step(0, 0, 8'hF4, 16'h0, 0);
        step(0, 0, 8'hF4, 16'h0, 1);

        // Overflow, drain, clear
        step(1, 0, 8'h00, 16'h0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, 8'hF0, 16'(i), 0);
        step(0, 0, 8'hF2, 16'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'hF2, 16'h0, 1);
        step(0, 0, 8'hF2, 16'h0, 0);
        step(0, 1, 8'hF2, 16'h0004, 0);
        step(0, 0, 8'hF2, 16'h0, 0);

        // Push into full FIFO while popping
        for (int i = 0; i < 4; i++) step(0, 1, 8'hF1, 16'h0100 + 16'(i), 0);
        step(0, 1, 8'hF0, 16'h00AA, 1);
        step(0, 0, 8'hF4, 16'h0, 0);
        step(0, 0, 8'hF2, 16'h0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'hF4, 16'h0, 1);

        // Overflow and clear in the same cycle, then miss-address traffic
        for (int i = 0; i < 4; i++) step(0, 1, 8'hF0, 16'h0200 + 16'(i), 0);
        step(0, 1, 8'hF0, 16'hDEAD, 0);
        step(0, 1, 8'hF2, 16'h0004, 0);
        step(0, 0, 8'hF2, 16'h0, 0);
        step(0, 0, 8'h10, 16'h0, 0);
        step(0, 1, 8'h10, 16'hFFFF, 0);
        step(0, 0, 8'hF4, 16'h0, 0);
        step(0, 0, 8'hFA, 16'h0, 0);

        // CYCLES load and wrap
        step(0, 1, 8'hF6, 16'hFFFE, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'hF6, 16'h0, 0);

        // Reset with entries queued and consumer ready
        step(1, 0, 8'h00, 16'h0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'hF0, 16'h0300 + 16'(i), 0);
        step(1, 0, 8'hF4, 16'h0, 1);
        step(0, 0, 8'hF4, 16'h0, 1);
        step(0, 0, 8'hF2, 16'h0, 1);
        step(0, 0, 8'hF6, 16'h0, 1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic       r;
            logic       w;
            logic [7:0] a;
            r = ($urandom_range(0, 99) == 0);
            w = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) a = 8'($urandom);
            else a = {4'hF, 4'($urandom_range(0, 9))};
            step(r, w, a, 16'($urandom), ($urandom_range(0, 2) == 0));
        end

        // Drain and settle
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 8'hF4, 16'h0, 1);
        step(0, 0, 8'h00, 16'h0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("pop_q_empty", 32'(pop_q.size()), 32'd0);
        chk("rd_q_empty", 32'(rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_port.md
MMIO_PORT -- requirements
Module: mmio_port

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO entries; power of two, 2..16.
REQ-002 Parameter BASE, default 8'hF0, byte-address base; the block is selected when addr[7:4]==BASE[7:4].
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 we  input  1  CPU write strobe; same signal as the CPU memory write enable.
REQ-006 addr  input  8  CPU byte address; word offset = addr[3:1]; addr[0] ignored.
REQ-007 wdata  input  16  CPU write data.
REQ-008 rdata  output  16  registered read data to the CPU read mux.
REQ-009 sel  output  1  registered; high when the previous cycle's addr hit the block; the system muxes rdata over memory data when sel=1.
REQ-010 out_valid  output  1  FIFO head valid.
REQ-011 out_data  output  16  FIFO head word.
REQ-012 out_ready  input  1  consumer accepts head.

Function
REQ-013 Hit = (addr[7:4]==BASE[7:4]); writes with hit=0 have no effect.
REQ-014 Register map (word offset): 0 DATA, 1 STATUS, 2 COUNT, 3 CYCLES, 4-7 reserved (read 0, writes ignored).
REQ-015 Read latency one cycle: rdata and sel at edge N+1 reflect addr and state sampled at edge N; reads have no side effects.
REQ-016 DATA write pushes wdata into the FIFO; DATA read returns 0.
REQ-017 STATUS read = {13'b0, ovf, full, empty}; STATUS write with wdata[2]=1 clears ovf; other bits ignored.
REQ-018 COUNT read = number of stored entries (0..DEPTH), zero-extended.
REQ-019 Pop occurs when out_valid && out_ready at the edge; out_valid = (count!=0); out_data = oldest entry, stable until popped.
REQ-020 Push when not full: entry stored, count+1 (unless a pop also occurs).
REQ-021 Push when full without a simultaneous pop: wdata dropped, count unchanged, ovf set to 1 (sticky).
REQ-022 Push when full with a simultaneous pop: push accepted, count stays DEPTH, ovf unchanged.
REQ-023 Push when empty: word stored; out_valid rises next cycle (no bypass).
REQ-024 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 A STATUS write that clears ovf while an overflow occurs in the same cycle leaves ovf=1 (set wins).

Reset
REQ-026 On rst=1 at an edge: count=0, pointers=0, ovf=0, rdata=0, sel=0, cycle counter=0; out_valid=0 the following cycle; FIFO storage contents need not be cleared.
REQ-027 rst takes priority over any simultaneous push, pop or write; words in flight are discarded.

Configuration
REQ-028 Macro MMIO_PORT_CYCLES_EN: when defined, CYCLES is a 16-bit free-running counter, +1 every cycle, wraps 16'hFFFF->0; a CYCLES write loads wdata (the next cycle increments from the loaded value).
REQ-029 Without MMIO_PORT_CYCLES_EN: no counter register exists, CYCLES reads 0, and writes to CYCLES are ignored.

Verification
REQ-030 Reset, then write 8'hF0<=16'h1234 and write 8'hF0<=16'h5678 with out_ready=0 -> COUNT reads 2, out_valid=1, out_data=16'h1234; raise out_ready for one cycle -> out_data=16'h5678, COUNT reads 1.
REQ-031 DEPTH=4, out_ready=0, five DATA writes 1..5 -> STATUS reads 16'h0006 (ovf, full); drain -> words 1,2,3,4 in order, then STATUS reads 16'h0005; write STATUS<=16'h0004 -> STATUS reads 16'h0001.
REQ-032 Full FIFO with out_ready=1 and a DATA write of 16'h00AA in the same cycle -> ovf stays 0, COUNT stays 4, 16'h00AA emerges last.
REQ-033 Read addr 8'h10 -> sel=0 next cycle; write 8'h10<=16'hFFFF -> COUNT unchanged; read 8'hFA -> sel=1, rdata=0.
REQ-034 With MMIO_PORT_CYCLES_EN: write CYCLES<=16'hFFFE, read back on consecutive cycles -> values wrap through 16'h0000; without the macro -> reads 0.
REQ-035 Assert rst with 3 entries queued and out_ready=1 -> next cycle out_valid=0, COUNT=0, ovf=0, no pop occurs.
